keypad_scan: RTL
================

// Module: keypad_scan
// PURPOSE
//  Column-driving scanner for the 4x4 Pmod keypad on JA: drives JA[3:0] one column low at a time and reads JA[7:4] rows.
//  Produces a debounced 4-bit key code, a one-cycle new-press strobe and a held level.
//  Feeds the player-B path into chara_control.
//  Replaces free-running row decode with a synchronised, ghost-rejecting, debounced scan.
// PARAMETERS
//  SCAN_DIV        100000  clk cycles each column is held low (1 ms @100 MHz); must be >= 4
//  DEBOUNCE_SCANS  4       consecutive identical full sweeps required to accept a press or a release
//  REPEAT_SWEEPS   64      sweeps between auto-repeat strobes (used only with KEYPAD_REPEAT_EN)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-high
//  row        in   4  keypad rows JA[7:4], active-low (pulled up; 0 = pressed in driven column)
//  col        out  4  keypad columns JA[3:0], one-hot active-low
//  key_code   out  4  debounced code of accepted key (valid while key_held or on key_valid)
//  key_valid  out  1  one-cycle strobe: new key accepted (or repeat, see CONFIGURATION)
//  key_held   out  1  high while accepted key remains stably pressed
// BEHAVIOUR
//  Reset (async): col=4'b1111, key_code=0, key_valid=0, key_held=0, column index=0, all counters=0, FSM=IDLE.
//  First cycle after release drives col=4'b1110.
//  Column drive:
//   - col[c] low for SCAN_DIV cycles, then c increments 0->1->2->3->0.
//   - col is registered and changes only at dwell boundaries.
//   - sweep = 4*SCAN_DIV cycles.
//  Row input:
//   - row passes a 2-flop synchroniser.
//   - sampled on last cycle of each column dwell (synchroniser settled since SCAN_DIV >= 4).
//  Sweep result, evaluated on last dwell cycle of column 3:
//   - NONE: no low rows seen.
//   - KEY(k): exactly one (row,col) low.
//   - MULTI: >1 low. MULTI is treated as NONE (ghost rejection).
//  Code map, row r / col c:
//   - r0: 1 2 3 A
//   - r1: 4 5 6 B
//   - r2: 7 8 9 C
//   - r3: 0 F E D
//  FSM (advances only at sweep end), cnt = match counter:
//   - IDLE: KEY(k) -> PRESS, cand=k, cnt=1. Else stay.
//   - PRESS: KEY(cand) -> cnt++; when cnt==DEBOUNCE_SCANS -> HELD, key_code=cand, key_valid=1 for that cycle, key_held=1.
//     Any other result -> IDLE, cnt=0.
//   - HELD: KEY(key_code) -> stay, cnt=0. NONE/MULTI/different key -> RELEASE, cnt=1.
//   - RELEASE: non-matching sweep -> cnt++; when cnt==DEBOUNCE_SCANS -> IDLE, key_held=0 (key_code keeps last value).
//     KEY(key_code) -> HELD, cnt=0, no strobe.
//  Latency:
//   - Press: key_valid asserts at end of DEBOUNCE_SCANS-th matching sweep.
//   - Release: key_held falls at end of DEBOUNCE_SCANS-th non-matching sweep.
//  Key change while held: needs full release, then full press debounce. No direct switch; key_valid then carries new code.
//  key_valid never high two consecutive cycles. Asserted only at sweep-end cycles.
//  Reset mid-sweep: immediate return to reset values; a partially debounced press is discarded.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined:
//   - In HELD, sweep counter counts matching sweeps.
//   - Every REPEAT_SWEEPS sweeps, key_valid pulses 1 cycle with unchanged key_code.
//   - Counter cleared on entry to HELD and on leaving it.
//  Undefined: key_valid only on initial acceptance; no repeat logic synthesised.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SWEEPS=3)
//  1. rst high then low -> col 1111 during reset; then 1110,1101,1011,0111 each 4 cycles, wrapping; outputs 0.
//  2. row[1] low whenever col[2] low, 3 sweeps -> key_valid single pulse, key_code=4'h6, at end of sweep 2; key_held=1.
//  3. From test 2, release for 1 sweep then press again -> key_held stays 1, no key_valid.
//     Then release 2 sweeps -> key_held=0.
//  4. row[3] low in col0 and row[0] low in col3 simultaneously (MULTI) -> no key_valid, key_held=0 throughout.
//  5. Press 'D' (r3,c3) for 1 sweep only -> no key_valid.
//     Assert rst mid-sweep during a 2-sweep press -> outputs reset, no strobe afterwards.
//  6. KEYPAD_REPEAT_EN, hold '5' for 10 sweeps -> key_valid at sweep 2, then every 3 sweeps (5, 8), code 4'h5.
//     Without macro -> only sweep 2.

Source files
------------

// File: rtl/keypad_scan_if.sv
// Keypad bus between the column-driving scanner and the rest of the design.
// master: the scanner (reads rows, drives columns and key outputs).
// slave : the keypad/consumer side.
interface keypad_scan_if;
    logic [3:0] row;       // JA[7:4], active-low, pulled up
    logic [3:0] col;       // JA[3:0], one-hot active-low
    logic [3:0] key_code;  // debounced code of the accepted key
    logic       key_valid; // one-cycle strobe: key accepted (or repeat)
    logic       key_held;  // accepted key still stably pressed

    modport master (
        input  row,
        output col, key_code, key_valid, key_held
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: one column driven low per dwell of SCAN_DIV cycles,
// rows synchronised and sampled at the end of each dwell, full-sweep result
// (none / single key / multiple keys) debounced over DEBOUNCE_SCANS sweeps.
// Multiple simultaneous keys are treated as no key (ghost rejection).
// Optional feature: define KEYPAD_REPEAT_EN to re-strobe key_valid every
// REPEAT_SWEEPS matching sweeps while a key is held.
// DEBOUNCE_SCANS must be >= 2, SCAN_DIV >= 4, REPEAT_SWEEPS >= 2.
module keypad_scan #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SWEEPS  = 64
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 2 || REPEAT_SWEEPS < 2) begin : g_param_check
        $error("keypad_scan: SCAN_DIV >= 4, DEBOUNCE_SCANS >= 2, REPEAT_SWEEPS >= 2 required");
    end

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    // Scan timing and row capture
    logic             started_q;   // low only for the first cycle after reset
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_idx_q;
    logic [3:0]       col_q;
    logic [3:0]       sync1_q, sync2_q;
    logic [1:0]       hit_cnt_q;   // lows seen so far this sweep, saturating at 2
    logic [3:0]       hit_code_q;  // code of the first low seen this sweep

    // Debounce FSM
    state_t           state_q;
    logic [3:0]       cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             key_held_q;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SWEEPS);
    logic [REP_W-1:0] rep_q;
`endif

    // Per-dwell decode
    logic       dwell_end, sweep_end;
    logic [3:0] rows_low;
    logic [2:0] col_hits, hits_sum;
    logic [1:0] low_row, hits_sat;
    logic [3:0] this_code, sweep_code;
    logic       sweep_is_key;

    function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: code_of = 4'h1;  4'h1: code_of = 4'h2;  4'h2: code_of = 4'h3;  4'h3: code_of = 4'hA;
            4'h4: code_of = 4'h4;  4'h5: code_of = 4'h5;  4'h6: code_of = 4'h6;  4'h7: code_of = 4'hB;
            4'h8: code_of = 4'h7;  4'h9: code_of = 4'h8;  4'hA: code_of = 4'h9;  4'hB: code_of = 4'hC;
            4'hC: code_of = 4'h0;  4'hD: code_of = 4'hF;  4'hE: code_of = 4'hE;  default: code_of = 4'hD;
        endcase
    endfunction

    // Decode the settled rows of the current column and the running sweep result
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        low_row   = 2'd0;
        dwell_end = started_q && (div_q == DIV_W'(SCAN_DIV - 1));
        sweep_end = dwell_end && (col_idx_q == 2'd3);
        rows_low  = ~sync2_q;
        col_hits  = {2'b00, rows_low[0]} + {2'b00, rows_low[1]}
                  + {2'b00, rows_low[2]} + {2'b00, rows_low[3]};
        for (int r = 3; r >= 0; r--) begin
            if (rows_low[r]) low_row = 2'(r);
        end
        this_code    = code_of(low_row, col_idx_q);
        hits_sum     = {1'b0, hit_cnt_q} + col_hits;
        hits_sat     = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
        sweep_is_key = (hits_sum == 3'd1);
        sweep_code   = (hit_cnt_q != 2'd0) ? hit_code_q : this_code;
    end

    // Column drive, row synchroniser and per-sweep hit accumulation
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register has an explicit reset value; there are no memories here.
        if (rst) begin
            started_q  <= 1'b0;
            div_q      <= '0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1111;
            sync1_q    <= 4'b1111;
            sync2_q    <= 4'b1111;
            hit_cnt_q  <= 2'd0;
            hit_code_q <= 4'h0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            sync1_q <= kp.row;
            sync2_q <= sync1_q;
            if (!started_q) begin
                started_q <= 1'b1;
                col_q     <= 4'b1110;
            end else if (dwell_end) begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                col_q     <= ~(4'b0001 << (col_idx_q + 2'd1));
                if (sweep_end) begin
                    hit_cnt_q <= 2'd0;
                end else begin
                    hit_cnt_q <= hits_sat;
                    if (hit_cnt_q == 2'd0 && col_hits != 3'd0) hit_code_q <= this_code;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // Debounce FSM with registered outputs, advanced only at sweep end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_q      <= 4'h0;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            if (sweep_end) begin
                case (state_q)
                    IDLE: begin
                        if (sweep_is_key) begin
                            state_q <= PRESS;
                            cand_q  <= sweep_code;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    PRESS: begin
                        if (sweep_is_key && sweep_code == cand_q) begin
                            if (int'(cnt_q) + 1 == DEBOUNCE_SCANS) begin
                                state_q     <= HELD;
                                cnt_q       <= '0;
                                key_code_q  <= cand_q;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                                rep_q       <= '0;
`endif
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    HELD: begin
                        if (sweep_is_key && sweep_code == key_code_q) begin
                            cnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (int'(rep_q) == REPEAT_SWEEPS - 1) begin
                                rep_q       <= '0;
                                key_valid_q <= 1'b1;
                            end else begin
                                rep_q <= rep_q + REP_W'(1);
                            end
`endif
                        end else begin
                            state_q <= RELEASE;
                            cnt_q   <= CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
                            rep_q   <= '0;
`endif
                        end
                    end
                    default: begin  // RELEASE
                        if (sweep_is_key && sweep_code == key_code_q) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_q   <= '0;
`endif
                        end else if (int'(cnt_q) + 1 == DEBOUNCE_SCANS) begin
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            key_held_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign kp.col       = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule
